pc_branch_ctrl: RTL and testbench

PC_BRANCH_CTRL -- requirements
Module: pc_branch_ctrl

---
 rtl/pc_branch_ctrl.sv | 113 +++++++++++
 tb/tb_pc_branch_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_ctrl.sv
// Program-counter sequencer with flag-conditioned branches through a 16-entry
// target LUT, a one-cycle bubble after each taken branch, and HALT handling.
module pc_branch_ctrl #(
    parameter int          PC_W       = 10,
    parameter int unsigned START_ADDR = 0
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic            flag_we,
    input  logic            z_in,
    input  logic            c_in,
    input  logic            n_in,
    input  logic            v_in,
    input  logic            br_en,
    input  logic [2:0]      br_cond,
    input  logic [3:0]      br_idx,
    input  logic            halt_in,
    input  logic            lut_we,
    input  logic [3:0]      lut_waddr,
    input  logic [PC_W-1:0] lut_wdata,
    output logic [PC_W-1:0] PC,
    output logic [3:0]      FLAGS,
    output logic            taken,
    output logic            stall,
    output logic            done
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {IDLE, RUN, BUBBLE, HALT} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_d;
    logic            taken_d;
    logic            cond_true;
    logic [PC_W-1:0] lut_q [16];

    // FLAGS is {z,c,n,v}; only the registered copy feeds the branch decision.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        cond_true = 1'b0;
        case (br_cond)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = FLAGS[3];
            3'b010:  cond_true = ~FLAGS[3];
            3'b011:  cond_true = FLAGS[1];
            3'b100:  cond_true = ~FLAGS[1];
            3'b101:  cond_true = FLAGS[2];
            3'b110:  cond_true = ~FLAGS[2];
            default: cond_true = FLAGS[0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = PC;
        taken_d = 1'b0;
        if (START) begin
            state_d = RUN;
            pc_d    = START_PC;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_in) begin
                        state_d = HALT;
                    end else if (br_en && cond_true) begin
                        state_d = BUBBLE;
                        pc_d    = lut_q[br_idx];
                        taken_d = 1'b1;
                    end else begin
                        pc_d = PC + PC_W'(1);
                    end
                end
                BUBBLE:  state_d = RUN;
                default: ;
            endcase
        end
    end

    // stall/done are registered decodes of the next state so they line up
    // with the cycle the FSM actually spends in BUBBLE/HALT.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            PC      <= START_PC;
            FLAGS   <= '0;
            taken   <= 1'b0;
            stall   <= 1'b0;
            done    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every
            // register samples pre-edge values regardless of statement order.
            state_q <= state_d;
            PC      <= pc_d;
            taken   <= taken_d;
            stall   <= (state_d == BUBBLE);
            done    <= (state_d == HALT);
            if (flag_we) FLAGS <= {z_in, c_in, n_in, v_in};
        end
    end

    // NOTE: the LUT is reset on purpose: branch targets must read as zero
    // after reset, so it is built from flops rather than a RAM macro.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 16; i++) lut_q[i] <= '0;
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed + randomized bench for pc_branch_ctrl, checked against a
// cycle-level behavioural model of the sequencer.
module tb_pc_branch_ctrl;

    localparam int PC_W = 10;
    localparam int PC_MOD = 1 << PC_W;

    logic            CLK = 1'b0;
    logic            RESET_N;
    logic            START, flag_we, z_in, c_in, n_in, v_in;
    logic            br_en, halt_in, lut_we;
    logic [2:0]      br_cond;
    logic [3:0]      br_idx, lut_waddr;
    logic [PC_W-1:0] lut_wdata;
    logic [PC_W-1:0] PC;
    logic [3:0]      FLAGS;
    logic            taken, stall, done;

    pc_branch_ctrl #(.PC_W(PC_W), .START_ADDR(0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .flag_we(flag_we),
        .z_in(z_in), .c_in(c_in), .n_in(n_in), .v_in(v_in),
        .br_en(br_en), .br_cond(br_cond), .br_idx(br_idx), .halt_in(halt_in),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .PC(PC), .FLAGS(FLAGS), .taken(taken), .stall(stall), .done(done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: mode 0=idle, 1=running, 2=bubble, 3=halted.
    int       m_mode;
    int       m_pc;
    bit [3:0] m_flags;
    int       m_lut [16];
    bit       m_taken, m_stall, m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_flags = 4'h0;
        m_taken = 0; m_stall = 0; m_done = 0;
        for (int i = 0; i < 16; i++) m_lut[i] = 0;
    endtask

    function automatic bit cond_holds(input logic [2:0] c, input bit [3:0] f);
        bit z, cy, n, v;
        {z, cy, n, v} = f;
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return !n;
            3'd5: return cy;
            3'd6: return !cy;
            default: return v;
        endcase
    endfunction

    task automatic model_step();
        bit ok;
        ok = cond_holds(br_cond, m_flags);
        m_taken = 0;
        if (START) begin
            m_mode = 1; m_pc = 0;
        end else if (m_mode == 1) begin
            if (halt_in) m_mode = 3;
            else if (br_en && ok) begin
                m_pc = m_lut[br_idx]; m_taken = 1; m_mode = 2;
            end else m_pc = (m_pc + 1) % PC_MOD;
        end else if (m_mode == 2) begin
            m_mode = 1;
        end
        m_stall = (m_mode == 2);
        m_done  = (m_mode == 3);
        if (flag_we) m_flags = {z_in, c_in, n_in, v_in};
        if (lut_we) m_lut[lut_waddr] = lut_wdata;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pc"},    32'(PC),    32'(m_pc));
        check({tag, ".flags"}, 32'(FLAGS), 32'(m_flags));
        check({tag, ".taken"}, 32'(taken), 32'(m_taken));
        check({tag, ".stall"}, 32'(stall), 32'(m_stall));
        check({tag, ".done"},  32'(done),  32'(m_done));
    endtask

    task automatic clear_inputs();
        START = 0; flag_we = 0; z_in = 0; c_in = 0; n_in = 0; v_in = 0;
        br_en = 0; br_cond = 3'd0; br_idx = 4'd0; halt_in = 0;
        lut_we = 0; lut_waddr = 4'd0; lut_wdata = '0;
    endtask

    task automatic cyc(input string tag);
        @(posedge CLK);
        model_step();
        #1 compare_all(tag);
    endtask

    // Async reset pulse placed between clock edges.
    task automatic reset_pulse(input string tag);
        #1 RESET_N = 1'b0;
        model_reset();
        #1 compare_all(tag);
        check({tag, ".pc0"}, 32'(PC), 32'h0);
        #1 RESET_N = 1'b1;
    endtask

    initial begin
        int pc_before;
        clear_inputs();
        RESET_N = 1'b0;
        model_reset();
        #3 compare_all("reset");
        #4 RESET_N = 1'b1;

        // Load targets while idle; PC must stay put.
        lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h120;
        cyc("idle_lut3");
        lut_waddr = 4'd5; lut_wdata = 10'h3FE;
        cyc("idle_lut5");
        lut_we = 0;
        check("idle_pc", 32'(PC), 32'h0);

        // Start and count up.
        START = 1; cyc("start");
        START = 0;
        check("start_pc", 32'(PC), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            cyc("count");
            check("count_pc", 32'(PC), 32'(i));
        end

        // Latch z, then branch on z through LUT[3].
        flag_we = 1; z_in = 1; cyc("flag_z1");
        flag_we = 0; z_in = 0;
        br_en = 1; br_cond = 3'b001; br_idx = 4'd3;
        cyc("br_z");
        check("br_pc", 32'(PC), 32'h120);
        check("br_taken", 32'(taken), 32'h1);
        check("br_stall", 32'(stall), 32'h1);
        cyc("bubble");
        check("bubble_pc", 32'(PC), 32'h120);
        check("bubble_taken", 32'(taken), 32'h0);
        check("bubble_stall", 32'(stall), 32'h0);
        br_en = 0;
        cyc("after_br");
        check("after_br_pc", 32'(PC), 32'h121);

        // Condition false, and same-cycle flag write must not be seen.
        flag_we = 1; z_in = 0; cyc("flag_z0");
        flag_we = 0;
        br_en = 1; br_cond = 3'b001; br_idx = 4'd3;
        pc_before = int'(PC);
        cyc("nobr1");
        check("nobr1_pc", 32'(PC), 32'(pc_before + 1));
        flag_we = 1; z_in = 1;
        cyc("nobr2");
        check("nobr2_pc", 32'(PC), 32'(pc_before + 2));
        check("nobr2_taken", 32'(taken), 32'h0);
        check("nobr2_flags", 32'(FLAGS), 32'h8);
        flag_we = 0; z_in = 0;

        // Branch to 0x3FE, wrap past all-ones, then halt vs branch.
        br_cond = 3'b000; br_idx = 4'd5;
        cyc("br_wrap");
        br_en = 0;
        cyc("wrap_bubble");
        cyc("wrap_3ff");
        check("wrap_3ff_pc", 32'(PC), 32'h3FF);
        cyc("wrap_0");
        check("wrap_0_pc", 32'(PC), 32'h000);
        cyc("wrap_1");
        halt_in = 1; br_en = 1; br_cond = 3'b000; br_idx = 4'd3;
        cyc("halt");
        check("halt_pc", 32'(PC), 32'h1);
        check("halt_done", 32'(done), 32'h1);
        check("halt_taken", 32'(taken), 32'h0);
        halt_in = 0; br_en = 0;
        cyc("halt_hold");
        START = 1; cyc("restart");
        START = 0;
        check("restart_pc", 32'(PC), 32'h0);
        check("restart_done", 32'(done), 32'h0);

        // Reset in the middle of a bubble clears the LUT too.
        br_en = 1; br_cond = 3'b000; br_idx = 4'd3;
        cyc("br_pre_rst");
        br_en = 0;
        reset_pulse("rst_bubble");
        START = 1; cyc("rst_start");
        START = 0;
        br_en = 1; br_cond = 3'b000; br_idx = 4'd3;
        cyc("br_cleared");
        check("br_cleared_pc", 32'(PC), 32'h0);
        check("br_cleared_taken", 32'(taken), 32'h1);
        br_en = 0;
        cyc("cleared_bubble");
        halt_in = 1; cyc("halt2");
        halt_in = 0;
        reset_pulse("rst_halt");

        // Randomized phase.
        for (int n = 0; n < 600; n++) begin
            START     = ($urandom_range(0, 39) == 0);
            halt_in   = ($urandom_range(0, 24) == 0);
            br_en     = ($urandom_range(0, 9) < 4);
            br_cond   = 3'($urandom_range(0, 7));
            br_idx    = 4'($urandom_range(0, 15));
            flag_we   = ($urandom_range(0, 1) == 1);
            {z_in, c_in, n_in, v_in} = 4'($urandom_range(0, 15));
            lut_we    = ($urandom_range(0, 9) < 3);
            lut_waddr = 4'($urandom_range(0, 15));
            lut_wdata = PC_W'($urandom_range(0, PC_MOD - 1));
            cyc("rand");
            if (n % 150 == 149) reset_pulse("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
